ps2_keymap: RTL and testbench

Parametrised PS/2 set-2 scancode decoder that turns the byte stream from the existing `ps2_intf` receiver into NUM_KEYS active-high button lines for the arcade core's input mux. It differs from the fixed 10-key mapper in four ways:
- a run-time loadable keymap (one 9-bit code per slot);
- a full prefix state machine that also swallows E1 (Pause) sequences;
- a prefix timeout and keyboard-replug release;
- per-slot autofire and a key-event strobe for the on-screen menu.

---
 rtl/ps2_keymap.sv | 158 +++++++++++++++
 tb/tb_ps2_keymap.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_keymap.sv
// PS/2 set-2 scancode decoder. Maps make/break codes onto NUM_KEYS button lines through a
// run-time loadable keymap. Also handles the E0/F0/E1 prefixes, a prefix timeout,
// keyboard-replug release and per-slot autofire.
module ps2_keymap #(
  parameter int NUM_KEYS       = 10,
  parameter int PREFIX_TIMEOUT = 65536,
  parameter int AUTOFIRE_DIV   = 1000000,
  localparam int AW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          keyb_data,
  input  logic                keyb_valid,
  input  logic                map_we,
  input  logic [AW-1:0]       map_addr,
  input  logic [8:0]          map_code,
  input  logic [NUM_KEYS-1:0] autofire_en,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] joystick,
  output logic                key_event,
  output logic [8:0]          key_code,
  output logic                key_release
);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam int FW = (AUTOFIRE_DIV > 2) ? $clog2(AUTOFIRE_DIV) : 1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  skip_q, skip_d;
  logic [TW-1:0]               to_cnt_q, to_cnt_d;
  logic [FW-1:0]               af_cnt_q;
  logic                        phase_q;
  logic [NUM_KEYS-1:0][8:0]    keymap_q, keymap_d;
  logic [NUM_KEYS-1:0]         held_q, held_d, joy_q;
  logic                        key_event_q, key_release_q;
  logic [8:0]                  key_code_q;

  logic       ev, ev_make, rel_all, addr_ok;
  logic [8:0] ev_code;

  function automatic logic [8:0] dflt(input int i);
    case (i)
      0: dflt = 9'h029;  1: dflt = 9'h016;  2: dflt = 9'h01E;  3: dflt = 9'h076;
      4: dflt = 9'h175;  5: dflt = 9'h172;  6: dflt = 9'h16B;  7: dflt = 9'h174;
      8: dflt = 9'h011;  9: dflt = 9'h00D;
      default: dflt = 9'h000;
    endcase
  endfunction

  assign addr_ok = (32'(map_addr) < NUM_KEYS);

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    to_cnt_d = '0;
    ev       = 1'b0;
    ev_make  = 1'b0;
    ev_code  = 9'h000;
    rel_all  = 1'b0;
    if (keyb_valid) begin
      case (state_q)
        IDLE: case (keyb_data)
          8'hE0:        state_d = EXT;
          8'hF0:        state_d = BRK;
          8'hE1:        begin state_d = SKIP; skip_d = 3'd7; end
          8'hAA:        rel_all = 1'b1;
          8'h00, 8'hFF: ;
          default:      begin ev = 1'b1; ev_make = 1'b1; ev_code = {1'b0, keyb_data}; end
        endcase
        EXT: begin
          state_d = IDLE;
          case (keyb_data)
            8'hF0: state_d = EXTBRK;
            // fake shifts and stray prefixes abandon the sequence silently
            8'h12, 8'h59, 8'hE0, 8'hE1, 8'h00, 8'hFF: ;
            default: begin ev = 1'b1; ev_make = 1'b1; ev_code = {1'b1, keyb_data}; end
          endcase
        end
        BRK: begin
          state_d = IDLE;
          if (keyb_data != 8'h00 && keyb_data != 8'hFF) begin
            ev = 1'b1; ev_code = {1'b0, keyb_data};
          end
        end
        EXTBRK: begin
          state_d = IDLE;
          case (keyb_data)
            8'h12, 8'h59, 8'h00, 8'hFF: ;
            default: begin ev = 1'b1; ev_code = {1'b1, keyb_data}; end
          endcase
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TW'(PREFIX_TIMEOUT - 1)) state_d = IDLE;
      else                                     to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // event match uses the old keymap; a same-cycle write to the slot overrides it
  always_comb begin
    held_d   = held_q;
    keymap_d = keymap_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (rel_all) held_d[i] = 1'b0;
      else if (ev && ev_code != 9'h000 && keymap_q[i] == ev_code) held_d[i] = ev_make;
      if (map_we && addr_ok && 32'(map_addr) == i) begin
        keymap_d[i] = map_code;
        held_d[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      skip_q        <= '0;
      to_cnt_q      <= '0;
      af_cnt_q      <= '0;
      phase_q       <= 1'b1;
      held_q        <= '0;
      joy_q         <= '0;
      key_event_q   <= 1'b0;
      key_code_q    <= 9'h000;
      key_release_q <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) keymap_q[i] <= dflt(i);
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      to_cnt_q    <= to_cnt_d;
      held_q      <= held_d;
      keymap_q    <= keymap_d;
      key_event_q <= ev;
      if (ev) begin
        key_code_q    <= ev_code;
        key_release_q <= ~ev_make;
      end
      if (af_cnt_q == FW'(AUTOFIRE_DIV - 1)) begin
        af_cnt_q <= '0;
        phase_q  <= ~phase_q;
      end else begin
        af_cnt_q <= af_cnt_q + 1'b1;
      end
      joy_q <= held_q & (~autofire_en | {NUM_KEYS{phase_q}});
    end
  end

  assign held        = held_q;
  assign joystick    = joy_q;
  assign key_event   = key_event_q;
  assign key_code    = key_code_q;
  assign key_release = key_release_q;
endmodule

// File: tb/tb_ps2_keymap.sv
// Bench for ps2_keymap. Directed sequences are followed by random byte streams. All of it is
// checked every cycle against a prefix-queue reference model.
module tb_ps2_keymap;
  localparam int NK = 10, PT = 16, DIV = 4;

  logic          clk = 1'b0, reset = 1'b1;
  logic [7:0]    keyb_data = '0;
  logic          keyb_valid = 1'b0, map_we = 1'b0;
  logic [3:0]    map_addr = '0;
  logic [8:0]    map_code = '0;
  logic [NK-1:0] autofire_en = '0;
  logic [NK-1:0] held, joystick;
  logic          key_event, key_release;
  logic [8:0]    key_code;

  ps2_keymap #(.NUM_KEYS(NK), .PREFIX_TIMEOUT(PT), .AUTOFIRE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .keyb_data(keyb_data), .keyb_valid(keyb_valid),
    .map_we(map_we), .map_addr(map_addr), .map_code(map_code), .autofire_en(autofire_en),
    .held(held), .joystick(joystick), .key_event(key_event), .key_code(key_code),
    .key_release(key_release));

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: the pending prefix bytes are kept as a queue
  logic [8:0]    dk [NK] = '{9'h029, 9'h016, 9'h01E, 9'h076, 9'h175,
                             9'h172, 9'h16B, 9'h174, 9'h011, 9'h00D};
  logic [8:0]    km [NK];
  logic [7:0]    pfx [$];
  int            skip, idle_n, k;
  logic [NK-1:0] mh, mjoy;
  logic          mev, mrel;
  logic [8:0]    mcode;

  task automatic model_reset();
    for (int i = 0; i < NK; i++) km[i] = dk[i];
    pfx.delete();
    skip = 0; idle_n = 0; k = 0;
    mh = '0; mjoy = '0; mev = 0; mrel = 0; mcode = 9'h000;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic ev, mk, ext, brk, fake, junk;
    logic [8:0] c;
    ev = 0; mk = 0; c = 9'h000;
    fake = (b == 8'h12 || b == 8'h59);
    junk = (b == 8'h00 || b == 8'hFF);
    if (skip > 0) skip--;
    else if (pfx.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0) pfx.push_back(b);
      else if (b == 8'hE1) skip = 7;
      else if (b == 8'hAA) mh = '0;
      else if (!junk) begin ev = 1; mk = 1; c = {1'b0, b}; end
    end else begin
      ext = (pfx[0] == 8'hE0);
      brk = (pfx[pfx.size()-1] == 8'hF0);
      if (ext && !brk && b == 8'hF0) pfx.push_back(b);
      else begin
        pfx.delete();
        if (ext && !brk) begin
          if (!fake && !junk && b != 8'hE0 && b != 8'hE1) begin ev = 1; mk = 1; c = {1'b1, b}; end
        end else if (!ext) begin
          if (!junk) begin ev = 1; c = {1'b0, b}; end
        end else begin
          if (!fake && !junk) begin ev = 1; c = {1'b1, b}; end
        end
      end
    end
    idle_n = 0;
    if (ev) begin
      mev = 1; mcode = c; mrel = !mk;
      for (int i = 0; i < NK; i++) if (km[i] == c) mh[i] = mk;
    end
  endtask

  task automatic model_edge(input logic rst, input logic v, input logic [7:0] b,
                            input logic we, input logic [3:0] a, input logic [8:0] c);
    if (rst) model_reset();
    else begin
      mjoy = mh & (~autofire_en | {NK{((k / DIV) % 2) == 0}});
      k++;
      mev = 0;
      if (v) model_byte(b);
      else if (pfx.size() > 0 || skip > 0) begin
        idle_n++;
        if (idle_n == PT) begin pfx.delete(); skip = 0; idle_n = 0; end
      end
      if (we && a < NK) begin km[a] = c; mh[a] = 0; end
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [7:0] b,
                      input logic we, input logic [3:0] a, input logic [8:0] c);
    reset = rst; keyb_valid = v; keyb_data = b; map_we = we; map_addr = a; map_code = c;
    @(posedge clk);
    model_edge(rst, v, b, we, a, c);
    #1;
    chk("held", 32'(held), 32'(mh));
    chk("joystick", 32'(joystick), 32'(mjoy));
    chk("key_event", 32'(key_event), 32'(mev));
    chk("key_code", 32'(key_code), 32'(mcode));
    chk("key_release", 32'(key_release), 32'(mrel));
  endtask

  task automatic send(input logic [7:0] b); step(0, 1, b, 0, 0, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [3:0] a, input logic [8:0] c); step(0, 0, 0, 1, a, c); endtask

  logic [7:0] pool [21] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'h00, 8'hFF, 8'h12, 8'h59, 8'h29, 8'h16,
                            8'h1E, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h11, 8'h0D, 8'h1C, 8'h14, 8'h77};
  logic [8:0] cpool [6] = '{9'h000, 9'h029, 9'h175, 9'h01C, 9'h11C, 9'h014};

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_code", 32'(key_code), 32'h000);

    send(8'h29);  chk("tp_make_held0", 32'(held[0]), 1); chk("tp_make_ev", 32'(key_event), 1);
    idle(1);      chk("tp_make_joy0", 32'(joystick[0]), 1);
    send(8'hF0); send(8'h29);
    chk("tp_brk_held0", 32'(held[0]), 0); chk("tp_brk_rel", 32'(key_release), 1);
    idle(1);      chk("tp_brk_joy0", 32'(joystick[0]), 0);

    send(8'hE0); send(8'h12); chk("tp_fake_noev", 32'(key_event), 0);
    send(8'hE0); send(8'h75); chk("tp_ext_held4", 32'(held[4]), 1); chk("tp_ext_code", 32'(key_code), 32'h175);
    send(8'hE0); send(8'hF0); send(8'h75); chk("tp_extbrk_held4", 32'(held[4]), 0);
    send(8'hE0); send(8'hF0); send(8'h12); chk("tp_fakebrk_noev", 32'(key_event), 0);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("tp_pause_code", 32'(key_code), 32'h175);
    send(8'hE0); idle(PT); send(8'h75);
    chk("tp_tmo_code", 32'(key_code), 32'h075); chk("tp_tmo_held4", 32'(held[4]), 0);

    send(8'h1E);  chk("tp_remap_pre", 32'(held[2]), 1);
    wr(4'd2, 9'h01C); chk("tp_remap_clr", 32'(held[2]), 0);
    send(8'h1E);  chk("tp_remap_old", 32'(held[2]), 0);
    send(8'h1C);  chk("tp_remap_new", 32'(held[2]), 1);
    wr(4'd10, 9'h029);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h1E);

    autofire_en = 10'b1;
    send(8'h29); idle(20);
    send(8'hF0); send(8'h29); idle(3);
    autofire_en = '0;

    send(8'h29); send(8'hE0); send(8'h72); send(8'hE0); send(8'h74);
    chk("tp_replug_pre", 32'(held), 32'h0A1);
    send(8'hAA);  chk("tp_replug_held", 32'(held), 0);
    idle(1);      chk("tp_replug_joy", 32'(joystick), 0);

    send(8'hE0); send(8'hF0);
    step(1, 0, 0, 0, 0, 0);
    chk("tp_rst_held", 32'(held), 0); chk("tp_rst_code", 32'(key_code), 0);
    idle(1); send(8'h75);
    chk("tp_rst_make", 32'(key_code), 32'h075); chk("tp_rst_rel", 32'(key_release), 0);

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] b;
      if ($urandom_range(0, 15) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 20)];
      if ($urandom_range(0, 99) == 0) autofire_en = NK'($urandom);
      if ($urandom_range(0, 499) == 0) step(1, 0, 0, 0, 0, 0);
      else if ($urandom_range(0, 80) == 0) idle(PT - 1 + $urandom_range(0, 2));
      else if ($urandom_range(0, 29) == 0)
        step(0, $urandom_range(0, 1), b, 1, 4'($urandom_range(0, 11)),
             ($urandom_range(0, 6) == 0) ? 9'($urandom) : cpool[$urandom_range(0, 5)]);
      else step(0, $urandom_range(0, 9) < 7, b, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
